ex_stage_exmem: RTL and testbench

- Execute stage of the 5-stage MIPS-style pipeline. Sits directly downstream of the ID/EX register and consumes its outputs.
- Performs operand selection, ALU operation, destination-register select and branch-target computation, and registers the results as the EX/MEM pipeline register.
- Adds a multi-cycle shift-add multiplier that stalls upstream via busy.

---
 rtl/ex_stage_exmem.sv | 264 ++++++++++++++++++++++++++
 tb/tb_ex_stage_exmem.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage_exmem.sv
// ex_stage_exmem: execute stage plus EX/MEM pipeline register of a 5-stage
// MIPS-style pipeline. Selects the operands, runs the ALU, picks the write-back
// register and computes the branch target. A DW-iteration shift-add multiplier
// (aluc=101) holds the stage busy while it runs.
//
// Optional build macro: FORWARD_EN adds rs/rt operand forwarding from this
// stage's own EX/MEM result and from the write-back stage.
//
// Ports:
//   clk, rst (sync, active high), flush (sync squash of EX/MEM and any MUL)
//   in_valid, Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, RegDest,
//   aluc[2:0], Read_out1/Read_out2/Signextended/incinst[DW-1:0], addr1/addr2[4:0]
//   FORWARD_EN only: addr_rs[4:0], wb_RegWrite, wb_rd[4:0], wb_data[DW-1:0]
//   busy: MUL in progress, upstream must hold ID/EX
//   valid_out, BranchOut, MemReadOut, MemtoRegOut, MemWriteOut, RegWriteOut,
//   zeroOut, aluResultOut, storeDataOut, branchTargetOut, destRegOut
module ex_stage_exmem #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic          Branch,
  input  logic          MemRead,
  input  logic          MemtoReg,
  input  logic          MemWrite,
  input  logic          ALUSrc,
  input  logic          RegWrite,
  input  logic          RegDest,
  input  logic [2:0]    aluc,
  input  logic [DW-1:0] Read_out1,
  input  logic [DW-1:0] Read_out2,
  input  logic [DW-1:0] Signextended,
  input  logic [DW-1:0] incinst,
  input  logic [4:0]    addr1,
  input  logic [4:0]    addr2,
`ifdef FORWARD_EN
  input  logic [4:0]    addr_rs,
  input  logic          wb_RegWrite,
  input  logic [4:0]    wb_rd,
  input  logic [DW-1:0] wb_data,
`endif
  output logic          busy,
  output logic          valid_out,
  output logic          BranchOut,
  output logic          MemReadOut,
  output logic          MemtoRegOut,
  output logic          MemWriteOut,
  output logic          RegWriteOut,
  output logic          zeroOut,
  output logic [DW-1:0] aluResultOut,
  output logic [DW-1:0] storeDataOut,
  output logic [DW-1:0] branchTargetOut,
  output logic [4:0]    destRegOut
);

  localparam int unsigned CW     = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [2:0]  OP_MUL = 3'b101;

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          w_issue;
  logic          w_capture;
  logic          w_finish;
  logic          w_mul_step;

  logic [DW-1:0] w_rs_val;
  logic [DW-1:0] w_rt_val;
  logic [DW-1:0] w_op_a;
  logic [DW-1:0] w_op_b;
  logic [DW-1:0] w_alu;
  logic [DW-1:0] w_target;
  logic [4:0]    w_dest;

  logic [DW-1:0] r_mcand;
  logic [DW-1:0] r_mplier;
  logic [DW-1:0] r_acc;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] w_acc_step;
  logic          w_mul_last;

  logic [4:0]    r_cap_ctl;
  logic [4:0]    r_cap_dest;
  logic [DW-1:0] r_cap_target;
  logic [DW-1:0] r_cap_store;

  // Operand sourcing: register-file values, optionally overridden by bypass.
`ifdef FORWARD_EN
  logic w_exm_ok;
  assign w_exm_ok = valid_out & RegWriteOut & ~MemReadOut;

  always_comb begin
    w_rs_val = Read_out1;
    if (addr_rs != 5'd0) begin
      if (w_exm_ok && (destRegOut == addr_rs))
        w_rs_val = aluResultOut;
      else if (wb_RegWrite && (wb_rd == addr_rs))
        w_rs_val = wb_data;
    end
  end

  always_comb begin
    w_rt_val = Read_out2;
    if (addr1 != 5'd0) begin
      if (w_exm_ok && (destRegOut == addr1))
        w_rt_val = aluResultOut;
      else if (wb_RegWrite && (wb_rd == addr1))
        w_rt_val = wb_data;
    end
  end
`else
  assign w_rs_val = Read_out1;
  assign w_rt_val = Read_out2;
`endif

  assign w_op_a   = w_rs_val;
  assign w_op_b   = ALUSrc ? Signextended : w_rt_val;
  assign w_dest   = RegDest ? addr2 : addr1;
  assign w_target = incinst + (Signextended << 2);

  // Single-cycle ALU; MUL results come from the iterative unit instead.
  always_comb begin
    w_alu = '0;
    case (aluc)
      3'b000:  w_alu = w_op_a & w_op_b;
      3'b001:  w_alu = w_op_a | w_op_b;
      3'b010:  w_alu = w_op_a + w_op_b;
      3'b011:  w_alu = ~(w_op_a | w_op_b);
      3'b100:  w_alu = w_op_a ^ w_op_b;
      3'b110:  w_alu = w_op_a - w_op_b;
      3'b111:  w_alu = DW'($signed(w_op_a) < $signed(w_op_b));
      default: w_alu = '0;
    endcase
  end

  // Shift-add: the last iteration's partial sum goes straight into EX/MEM.
  assign w_acc_step = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_last = (r_cnt == CW'(DW - 1));

  // FSM next state and per-edge load decisions; flush squashes everything.
  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_capture   = 1'b0;
    w_finish    = 1'b0;
    w_mul_step  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          if (aluc == OP_MUL) begin
            w_capture   = 1'b1;
            w_state_nxt = S_MUL;
          end else begin
            w_issue = 1'b1;
          end
        end
      end
      S_MUL: begin
        w_mul_step = 1'b1;
        if (w_mul_last) begin
          w_finish    = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) begin
      w_state_nxt = S_IDLE;
      w_issue     = 1'b0;
      w_capture   = 1'b0;
      w_finish    = 1'b0;
      w_mul_step  = 1'b0;
    end
  end

  // State register; busy mirrors the registered state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      busy    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      busy    <= (w_state_nxt == S_MUL);
    end
  end

  // Multiplier datapath and captured MUL instruction context.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand      <= '0;
      r_mplier     <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_cap_ctl    <= '0;
      r_cap_dest   <= '0;
      r_cap_target <= '0;
      r_cap_store  <= '0;
    end else if (flush) begin
      r_cnt <= '0;
    end else if (w_capture) begin
      r_mcand      <= w_op_a;
      r_mplier     <= w_op_b;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_cap_ctl    <= {Branch, MemRead, MemtoReg, MemWrite, RegWrite};
      r_cap_dest   <= w_dest;
      r_cap_target <= w_target;
      r_cap_store  <= w_rt_val;
    end else if (w_mul_step) begin
      r_acc    <= w_acc_step;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= w_mul_last ? '0 : r_cnt + CW'(1);
    end
  end

  // EX/MEM register: bubbles clear valid and controls but keep the data.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out       <= 1'b0;
      BranchOut       <= 1'b0;
      MemReadOut      <= 1'b0;
      MemtoRegOut     <= 1'b0;
      MemWriteOut     <= 1'b0;
      RegWriteOut     <= 1'b0;
      zeroOut         <= 1'b0;
      aluResultOut    <= '0;
      storeDataOut    <= '0;
      branchTargetOut <= '0;
      destRegOut      <= '0;
    end else if (w_issue) begin
      valid_out       <= 1'b1;
      BranchOut       <= Branch;
      MemReadOut      <= MemRead;
      MemtoRegOut     <= MemtoReg;
      MemWriteOut     <= MemWrite;
      RegWriteOut     <= RegWrite;
      zeroOut         <= (w_alu == '0);
      aluResultOut    <= w_alu;
      storeDataOut    <= w_rt_val;
      branchTargetOut <= w_target;
      destRegOut      <= w_dest;
    end else if (w_finish) begin
      valid_out       <= 1'b1;
      {BranchOut, MemReadOut, MemtoRegOut, MemWriteOut, RegWriteOut} <= r_cap_ctl;
      zeroOut         <= (w_acc_step == '0);
      aluResultOut    <= w_acc_step;
      storeDataOut    <= r_cap_store;
      branchTargetOut <= r_cap_target;
      destRegOut      <= r_cap_dest;
    end else begin
      valid_out   <= 1'b0;
      BranchOut   <= 1'b0;
      MemReadOut  <= 1'b0;
      MemtoRegOut <= 1'b0;
      MemWriteOut <= 1'b0;
      RegWriteOut <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ex_stage_exmem.sv
// tb_ex_stage_exmem: scoreboard bench for ex_stage_exmem (DW=32).
module tb_ex_stage_exmem;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid;
  logic          Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, RegDest;
  logic [2:0]    aluc;
  logic [DW-1:0] Read_out1, Read_out2, Signextended, incinst;
  logic [4:0]    addr1, addr2;
`ifdef FORWARD_EN
  logic [4:0]    addr_rs;
  logic          wb_RegWrite;
  logic [4:0]    wb_rd;
  logic [DW-1:0] wb_data;
`endif
  logic          busy, valid_out;
  logic          BranchOut, MemReadOut, MemtoRegOut, MemWriteOut, RegWriteOut, zeroOut;
  logic [DW-1:0] aluResultOut, storeDataOut, branchTargetOut;
  logic [4:0]    destRegOut;

  ex_stage_exmem #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .Branch(Branch), .MemRead(MemRead), .MemtoReg(MemtoReg), .MemWrite(MemWrite),
    .ALUSrc(ALUSrc), .RegWrite(RegWrite), .RegDest(RegDest), .aluc(aluc),
    .Read_out1(Read_out1), .Read_out2(Read_out2), .Signextended(Signextended),
    .incinst(incinst), .addr1(addr1), .addr2(addr2),
`ifdef FORWARD_EN
    .addr_rs(addr_rs), .wb_RegWrite(wb_RegWrite), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
    .busy(busy), .valid_out(valid_out), .BranchOut(BranchOut), .MemReadOut(MemReadOut),
    .MemtoRegOut(MemtoRegOut), .MemWriteOut(MemWriteOut), .RegWriteOut(RegWriteOut),
    .zeroOut(zeroOut), .aluResultOut(aluResultOut), .storeDataOut(storeDataOut),
    .branchTargetOut(branchTargetOut), .destRegOut(destRegOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] alu, st, tgt;
    logic [4:0]    dst;
    logic [4:0]    ctl;
    logic          z;
    int            cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] model_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b011:  return ~(a | b);
      3'b100:  return a ^ b;
      3'b101:  return a * b;
      3'b110:  return a - b;
      default: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Result monitor: every valid EX/MEM entry must match the oldest expectation.
  always @(posedge clk) begin
    #1;
    if (!rst && valid_out) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 64'(valid_out), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("latency_cycle", 64'(cyc), 64'(e.cyc));
        check("aluResultOut", 64'(aluResultOut), 64'(e.alu));
        check("zeroOut", 64'(zeroOut), 64'(e.z));
        check("storeDataOut", 64'(storeDataOut), 64'(e.st));
        check("branchTargetOut", 64'(branchTargetOut), 64'(e.tgt));
        check("destRegOut", 64'(destRegOut), 64'(e.dst));
        check("ctl_out", 64'({BranchOut, MemReadOut, MemtoRegOut, MemWriteOut, RegWriteOut}),
              64'(e.ctl));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one instruction on the ID/EX side and optionally log its result.
  task automatic drive(input logic [2:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [DW-1:0] imm, input logic [DW-1:0] pc,
                       input logic alusrc, input logic regdst,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] ctl, input bit push);
    exp_t e;
    aluc = op; Read_out1 = a; Read_out2 = b; Signextended = imm; incinst = pc;
    ALUSrc = alusrc; RegDest = regdst; addr1 = rt; addr2 = rd;
    {Branch, MemRead, MemtoReg, MemWrite, RegWrite} = ctl;
    in_valid = 1'b1;
    e.alu = model_alu(op, a, alusrc ? imm : b);
    e.z   = (e.alu == '0);
    e.st  = b;
    e.tgt = pc + (imm << 2);
    e.dst = regdst ? rd : rt;
    e.ctl = ctl;
    e.cyc = cyc + 1 + ((op == 3'b101) ? int'(DW) : 0);
    if (push) sb.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) step();
    check("busy_timeout", 64'(busy), 64'd0);
  endtask

  logic [2:0] ops [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b111};

  initial begin
    // Reset with every input driven high.
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1;
    {Branch, MemRead, MemtoReg, MemWrite, ALUSrc, RegWrite, RegDest} = '1;
    aluc = '1; Read_out1 = '1; Read_out2 = '1; Signextended = '1; incinst = '1;
    addr1 = '1; addr2 = '1;
`ifdef FORWARD_EN
    addr_rs = '1; wb_RegWrite = 1'b1; wb_rd = '1; wb_data = '1;
`endif
    step();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_ctl", 64'({BranchOut, MemReadOut, MemtoRegOut, MemWriteOut, RegWriteOut, zeroOut}), 64'd0);
    check("rst_data", {aluResultOut, storeDataOut}, 64'd0);
    check("rst_tgt_dst", 64'({branchTargetOut, destRegOut}), 64'd0);
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
`ifdef FORWARD_EN
    addr_rs = '0; wb_RegWrite = 1'b0; wb_rd = '0; wb_data = '0;
`endif
    step();

    // Directed ADD, SUB-to-zero with Branch, signed SLT.
    drive(3'b010, 32'd5, 32'd0, 32'd7, 32'h100, 1'b1, 1'b1, 5'd0, 5'd9, 5'b00000, 1'b1);
    step();
    // Bubble: controls clear, data holds.
    in_valid = 1'b0; Read_out1 = 32'd99;
    step();
    check("bubble_valid", 64'(valid_out), 64'd0);
    check("bubble_ctl", 64'({BranchOut, RegWriteOut}), 64'd0);
    check("bubble_hold_alu", 64'(aluResultOut), 64'd12);
    check("bubble_hold_dst", 64'(destRegOut), 64'd9);
    drive(3'b110, 32'h1234, 32'h1234, 32'd0, 32'h200, 1'b0, 1'b0, 5'd0, 5'd1, 5'b10000, 1'b1);
    step();
    drive(3'b111, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'h300, 1'b0, 1'b0, 5'd0, 5'd2, 5'b00000, 1'b1);
    step();

    // Back-to-back random single-cycle operations.
    for (int i = 0; i < 16; i++) begin
      logic [4:0] c;
      c = 5'($urandom);
`ifdef FORWARD_EN
      c[0] = 1'b0;
`endif
      drive(ops[$urandom_range(0, 6)], $urandom, $urandom, $urandom, $urandom,
            1'($urandom), 1'($urandom), 5'($urandom), 5'($urandom), c, 1'b1);
      step();
    end

    // MUL with held follow-on ADD: busy spans edges N..N+DW.
    drive(3'b101, 32'h0000_FFFF, 32'h0001_0001, 32'd0, 32'h400, 1'b0, 1'b1, 5'd0, 5'd7, 5'b00001, 1'b1);
    step();
    drive(3'b010, 32'd3, 32'd4, 32'd0, 32'h404, 1'b0, 1'b1, 5'd0, 5'd8, 5'b00000, 1'b0);
    for (int k = 0; k < int'(DW); k++) begin
      check("mul_busy", 64'(busy), 64'd1);
      step();
    end
    check("mul_busy_done", 64'(busy), 64'd0);
    drive(3'b010, 32'd3, 32'd4, 32'd0, 32'h404, 1'b0, 1'b1, 5'd0, 5'd8, 5'b00000, 1'b1);
    step();

    // Random MUL with immediate operand.
    drive(3'b101, $urandom, $urandom, $urandom, $urandom, 1'b1, 1'b0, 5'd11, 5'd0, 5'b01010, 1'b1);
    step();
    in_valid = 1'b0;
    wait_idle();
    step();

    // Flush on the 10th MUL edge aborts it; the next instruction runs normally.
    drive(3'b101, 32'd6, 32'd7, 32'd0, 32'h500, 1'b0, 1'b1, 5'd0, 5'd5, 5'b00001, 1'b0);
    step();
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_valid", 64'(valid_out), 64'd0);
    drive(3'b001, 32'hF0, 32'h0F, 32'd0, 32'h600, 1'b0, 1'b0, 5'd4, 5'd0, 5'b00000, 1'b1);
    step();
    in_valid = 1'b0;
    repeat (40) step();

    // Flush squashes a single-cycle instruction.
    drive(3'b010, 32'd1, 32'd1, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'b00001, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_single_valid", 64'(valid_out), 64'd0);
    check("flush_single_regwr", 64'(RegWriteOut), 64'd0);

    // Reset in the middle of a MUL aborts it.
    drive(3'b101, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0, 1'b0, 5'd0, 5'd0, 5'b00001, 1'b0);
    step();
    repeat (3) step();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    check("rst_mid_mul_busy", 64'(busy), 64'd0);
    repeat (40) step();

`ifdef FORWARD_EN
    // EX/MEM forwarding on rs, EX/MEM over WB priority, r0 never forwarded, WB on rt.
    drive(3'b010, 32'd10, 32'd0, 32'd10, 32'd0, 1'b1, 1'b1, 5'd0, 5'd3, 5'b00001, 1'b1);
    step();
    drive(3'b010, 32'd20, 32'd0, 32'd1, 32'd0, 1'b1, 1'b1, 5'd0, 5'd3, 5'b00001, 1'b1);
    Read_out1 = 32'd0; addr_rs = 5'd3;
    step();
    drive(3'b010, 32'd21, 32'd0, 32'd1, 32'd0, 1'b1, 1'b1, 5'd0, 5'd3, 5'b00001, 1'b1);
    Read_out1 = 32'd0; addr_rs = 5'd3; wb_RegWrite = 1'b1; wb_rd = 5'd3; wb_data = 32'd50;
    step();
    drive(3'b010, 32'd7, 32'd0, 32'd1, 32'd0, 1'b1, 1'b1, 5'd0, 5'd4, 5'b00000, 1'b1);
    addr_rs = 5'd0; wb_rd = 5'd0;
    step();
    drive(3'b010, 32'd1, 32'd100, 32'd0, 32'd0, 1'b0, 1'b1, 5'd5, 5'd6, 5'b00000, 1'b1);
    Read_out2 = 32'd0; wb_rd = 5'd5; wb_data = 32'd100;
    step();
    in_valid = 1'b0; wb_RegWrite = 1'b0; wb_rd = '0; addr_rs = '0;
    repeat (3) step();
`endif

    in_valid = 1'b0;
    repeat (3) step();
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
